// File: rtl/wrr_dispatcher.sv
// Weighted round-robin dispatcher: routes a single beat stream onto WIDTH output
// registers. Each port owns a credit counter loaded from its field of `credits`;
// the lowest-index free port with credit takes the next beat and spends one credit.
// When every counter has been spent, all counters reload from `credits` in the same
// cycle, so dispatch never stalls on reload.
//
// Optional feature (macro WRR_DISPATCHER_FALLBACK_EN): when no free port has credit,
// the lowest-index free port takes the beat without spending credit (work-conserving).
// Without the macro, beats are only sent to ports holding credit.
//
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   credits       packed per-port weights, port i in [CREDIT_WIDTH*(i+1)-1 : CREDIT_WIDTH*i]
//   in_valid      source beat valid
//   in_data       source beat
//   in_ready      source beat accepted when high together with in_valid
//   out_valid     per-port beat held
//   out_data      per-port beat, port i in slice i
//   out_ready     per-port sink consume
//   dispatch_sel  registered one-hot of the port that took the last accepted beat
//   credit_avail  per-port counter nonzero
module wrr_dispatcher #(
  parameter int unsigned WIDTH        = 4,
  parameter int unsigned CREDIT_WIDTH = 4,
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned TOTAL_WIDTH  = CREDIT_WIDTH * WIDTH
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [TOTAL_WIDTH-1:0]      credits,
  input  logic                        in_valid,
  input  logic [DATA_WIDTH-1:0]       in_data,
  output logic                        in_ready,
  output logic [WIDTH-1:0]            out_valid,
  output logic [DATA_WIDTH*WIDTH-1:0] out_data,
  input  logic [WIDTH-1:0]            out_ready,
  output logic [WIDTH-1:0]            dispatch_sel,
  output logic [WIDTH-1:0]            credit_avail
);

  logic [CREDIT_WIDTH-1:0]     cnt_q [WIDTH];
  logic [CREDIT_WIDTH-1:0]     cnt_d [WIDTH];
  logic [WIDTH-1:0]            out_valid_q;
  logic [DATA_WIDTH*WIDTH-1:0] out_data_q;
  logic [WIDTH-1:0]            dispatch_sel_q;

  logic [WIDTH-1:0] free;
  logic [WIDTH-1:0] primary;
  logic [WIDTH-1:0] fallback;
  logic [WIDTH-1:0] sel;
  logic             take_primary;
  logic             accept;
  logic             all_zero;

  always_comb begin
    for (int i = 0; i < WIDTH; i++) begin
      credit_avail[i] = |cnt_q[i];
    end
  end

  assign free    = ~out_valid_q | out_ready;
  assign primary = free & credit_avail;

`ifdef WRR_DISPATCHER_FALLBACK_EN
  assign fallback = free;
`else
  assign fallback = '0;
`endif

  assign take_primary = |primary;

  // x & -x isolates the lowest set bit.
  always_comb begin
    sel = '0;
    if (take_primary) begin
      sel = primary & (~primary + WIDTH'(1));
    end else begin
      sel = fallback & (~fallback + WIDTH'(1));
    end
  end

  assign in_ready = (|sel) & ~rst;
  assign accept   = in_valid & in_ready;

  // Spend one credit on a primary acceptance; reload everything once the last
  // credit is gone (this also holds zero counters at zero when credits are zero).
  always_comb begin
    all_zero = 1'b1;
    for (int i = 0; i < WIDTH; i++) begin
      cnt_d[i] = cnt_q[i] - CREDIT_WIDTH'(accept & take_primary & sel[i]);
      if (cnt_d[i] != '0) begin
        all_zero = 1'b0;
      end
    end
    if (all_zero) begin
      for (int i = 0; i < WIDTH; i++) begin
        cnt_d[i] = credits[CREDIT_WIDTH*i +: CREDIT_WIDTH];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < WIDTH; i++) begin
        cnt_q[i] <= credits[CREDIT_WIDTH*i +: CREDIT_WIDTH];
      end
      out_valid_q    <= '0;
      dispatch_sel_q <= '0;
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        cnt_q[i] <= cnt_d[i];
        if (accept && sel[i]) begin
          out_valid_q[i] <= 1'b1;
        end else if (out_ready[i]) begin
          out_valid_q[i] <= 1'b0;
        end
      end
      dispatch_sel_q <= accept ? sel : '0;
    end
  end

  // Beat storage carries no reset; validity lives in out_valid_q.
  always_ff @(posedge clk) begin
    for (int i = 0; i < WIDTH; i++) begin
      if (accept && sel[i]) begin
        out_data_q[DATA_WIDTH*i +: DATA_WIDTH] <= in_data;
      end
    end
  end

  assign out_valid    = out_valid_q;
  assign out_data     = out_data_q;
  assign dispatch_sel = dispatch_sel_q;

endmodule

// File: tb/tb_wrr_dispatcher.sv
module tb_wrr_dispatcher;

  localparam int W  = 4;
  localparam int CW = 4;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic [W*CW-1:0] credits;
  logic          in_valid;
  logic [DW-1:0] in_data;
  logic          in_ready;
  logic [W-1:0]  out_valid;
  logic [DW*W-1:0] out_data;
  logic [W-1:0]  out_ready;
  logic [W-1:0]  dispatch_sel;
  logic [W-1:0]  credit_avail;

  int n_checks = 0;
  int n_bad    = 0;

  // Reference model state
  int            m_cnt   [W];
  bit            m_valid [W];
  logic [DW-1:0] m_data  [W];
  logic [W-1:0]  m_sel;

`ifdef WRR_DISPATCHER_FALLBACK_EN
  localparam bit FallbackEn = 1'b1;
`else
  localparam bit FallbackEn = 1'b0;
`endif

  wrr_dispatcher #(
    .WIDTH       (W),
    .CREDIT_WIDTH(CW),
    .DATA_WIDTH  (DW),
    .TOTAL_WIDTH (W*CW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .credits     (credits),
    .in_valid    (in_valid),
    .in_data     (in_data),
    .in_ready    (in_ready),
    .out_valid   (out_valid),
    .out_data    (out_data),
    .out_ready   (out_ready),
    .dispatch_sel(dispatch_sel),
    .credit_avail(credit_avail)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // One clock cycle: drive, check in_ready, advance model, check registered outputs.
  task automatic step(input bit r, input bit v, input logic [DW-1:0] d,
                      input logic [W-1:0] ordy, input logic [W*CW-1:0] cr);
    int  p;
    bit  prim;
    bit  acc;
    bit  any_left;
    logic [W-1:0] exp_valid;
    logic [W-1:0] exp_avail;
    @(negedge clk);
    rst = r; in_valid = v; in_data = d; out_ready = ordy; credits = cr;
    #1;
    p = -1;
    prim = 1'b0;
    for (int i = 0; i < W; i++) begin
      if (p < 0 && (!m_valid[i] || ordy[i]) && m_cnt[i] > 0) begin
        p = i; prim = 1'b1;
      end
    end
    if (p < 0 && FallbackEn) begin
      for (int i = 0; i < W; i++) begin
        if (p < 0 && (!m_valid[i] || ordy[i])) p = i;
      end
    end
    check_eq("in_ready", 64'(in_ready), 64'(p >= 0 && !r));
    @(posedge clk);
    if (r) begin
      for (int i = 0; i < W; i++) begin
        m_cnt[i] = int'(cr[CW*i +: CW]);
        m_valid[i] = 1'b0;
      end
      m_sel = '0;
    end else begin
      acc = v && (p >= 0);
      for (int i = 0; i < W; i++) begin
        if (acc && i == p) begin
          m_valid[i] = 1'b1; m_data[i] = d;
        end else if (ordy[i]) begin
          m_valid[i] = 1'b0;
        end
      end
      if (acc && prim) m_cnt[p]--;
      any_left = 1'b0;
      for (int i = 0; i < W; i++) if (m_cnt[i] != 0) any_left = 1'b1;
      if (!any_left) for (int i = 0; i < W; i++) m_cnt[i] = int'(cr[CW*i +: CW]);
      m_sel = acc ? W'(1 << p) : '0;
    end
    #1;
    for (int i = 0; i < W; i++) begin
      exp_valid[i] = m_valid[i];
      exp_avail[i] = (m_cnt[i] != 0);
    end
    check_eq("out_valid", 64'(out_valid), 64'(exp_valid));
    check_eq("dispatch_sel", 64'(dispatch_sel), 64'(m_sel));
    check_eq("credit_avail", 64'(credit_avail), 64'(exp_avail));
    for (int i = 0; i < W; i++) begin
      if (m_valid[i]) check_eq($sformatf("out_data%0d", i), 64'(out_data[DW*i +: DW]),
                               64'(m_data[i]));
    end
  endtask

  initial begin
    int seq [14] = '{0, 0, 0, 1, 1, 2, 3, 0, 0, 0, 1, 1, 2, 3};
    logic [W*CW-1:0] cr;
    logic [W-1:0] one_hot;
    rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = '0; credits = '0;
    for (int i = 0; i < W; i++) begin
      m_cnt[i] = 0; m_valid[i] = 1'b0; m_data[i] = '0;
    end
    m_sel = '0;

    // Weighted sequence with all sinks ready: credits port3..0 = 1,1,2,3.
    cr = 16'h1123;
    step(1'b1, 1'b0, '0, 4'hF, cr);
    check_eq("reset_avail", 64'(credit_avail), 64'hF);
    for (int k = 0; k < 14; k++) begin
      step(1'b0, 1'b1, DW'(32'hA000 + k), 4'hF, cr);
      one_hot = W'(1 << seq[k]);
      check_eq($sformatf("wrr_seq%0d", k), 64'(dispatch_sel), 64'(one_hot));
    end

    // Port0 stalls after filling; it must keep its first beat.
    step(1'b1, 1'b0, '0, 4'hF, cr);
    for (int k = 0; k < 8; k++) step(1'b0, 1'b1, DW'(32'hB000 + k), 4'hE, cr);
    check_eq("port0_hold", 64'(out_data[DW-1:0]), 64'h0000B000);

    // No sinks ready: each port fills once, then stalls.
    step(1'b1, 1'b0, '0, 4'h0, cr);
    for (int k = 0; k < 6; k++) step(1'b0, 1'b1, DW'(32'hC000 + k), 4'h0, cr);
    check_eq("full_avail", 64'(credit_avail), 64'h3);

    // Mid-stream reset with all ports holding beats.
    step(1'b1, 1'b0, '0, 4'h0, cr);
    check_eq("rst_valid", 64'(out_valid), 64'h0);

    // All-zero credits.
    step(1'b1, 1'b0, '0, 4'hF, 16'h0);
    for (int k = 0; k < 5; k++) begin
      step(1'b0, 1'b1, DW'(32'hD000 + k), 4'hF, 16'h0);
      check_eq("zero_cr_sel", 64'(dispatch_sel), FallbackEn ? 64'h1 : 64'h0);
    end

    // Randomized traffic, credit changes, and occasional resets.
    cr = 16'h2314;
    step(1'b1, 1'b0, '0, 4'hF, cr);
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(0, 19) == 0) begin
        cr = ($urandom_range(0, 7) == 0) ? 16'h0 : 16'($urandom);
      end
      step($urandom_range(0, 49) == 0, $urandom_range(0, 3) != 0, $urandom,
           4'($urandom), cr);
    end

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule
